b2s_transmitter: RTL and testbench
==================================

Name: b2s_transmitter

Overview:
Upstream partner of the b2s receiver. It serialises a parallel word onto a single-wire pulse-width-coded line, b2s_dout. The line idles high. Each symbol is a low pulse whose length encodes it: start, bit 1 or bit 0. Each low pulse is followed by a fixed high gap. The transmitter and receiver run on the same-frequency clk, and all pulse lengths are counted in clk cycles.

Parameters:
WIDTH, 64, data bits per frame; must equal the receiver's WIDTH.
START_LOW, 240, low cycles of the start pulse; receiver accepts 231..249.
ONE_LOW, 16, low cycles for a 1 bit; receiver accepts 11..24.
ZERO_LOW, 96, low cycles for a 0 bit; receiver accepts 51..144.
HIGH_TIME, 32, high cycles after every low pulse; minimum 8, which covers receiver decode and shift.
FRAME_GAP, 64, extra idle-high cycles after the last bit before the next frame may start.

Ports:
clk  input  1  clock, same frequency as the receiver clk.
rst  input  1  synchronous, active-high reset.
din  input  WIDTH  word to send; sampled only when a frame is accepted.
start  input  1  frame request; honoured only while ready=1.
ready  output  1  high when idle and able to accept start.
busy  output  1  high from frame acceptance until done.
done  output  1  one-cycle pulse when a frame completes, including FRAME_GAP.
b2s_dout  output  1  serial line, registered, idle high.

Behaviour:
- Reset (rst=1 at a clk edge), effective next cycle:
  - b2s_dout=1, ready=1, busy=0, done=0.
  - State=IDLE; bit counter=0; shift register=0; cycle counter=0.
- Reset mid-frame aborts the frame immediately: line high the next cycle, no done pulse.
- The receiver resynchronises on the next start pulse.
- States: IDLE, START_L, START_H, BIT_L, BIT_H, GAP.
- IDLE:
  - b2s_dout=1.
  - If start=1, latch din into the shift register, clear the bit counter, load the cycle counter, go to START_L.
  - ready falls and busy rises in the same cycle.
  - start while not in IDLE is ignored; it is not queued.
- START_L: b2s_dout=0 for exactly START_LOW cycles, starting the cycle after acceptance. Then START_H.
- START_H: b2s_dout=1 for exactly HIGH_TIME cycles. Then BIT_L.
- BIT_L:
  - b2s_dout=0 for ONE_LOW cycles if shift register bit 0 is 1, else for ZERO_LOW cycles.
  - Pulse length is chosen on entry to the state.
- BIT_H:
  - b2s_dout=1 for HIGH_TIME cycles.
  - On its last cycle: shift the register right by 1 and increment the bit counter.
  - If bit counter reaches WIDTH, go to GAP; else go to BIT_L.
- Bit order is LSB first. din[0] is sent first, matching the receiver's MSB-insert/right-shift assembly.
- GAP: b2s_dout=1 for FRAME_GAP cycles. On exit, done=1 for one cycle, busy=0 and ready=1 in that same cycle, and state returns to IDLE.
- start is accepted in the cycle after done, never in the same cycle as done.
- Frame length, from the acceptance edge to the done cycle inclusive: START_LOW + HIGH_TIME + N1*ONE_LOW + N0*ZERO_LOW + WIDTH*HIGH_TIME + FRAME_GAP cycles. N1 and N0 are the counts of 1 and 0 bits in the word.
- Cycle counter:
  - Width is clog2 of the largest of START_LOW, ZERO_LOW, ONE_LOW, HIGH_TIME, FRAME_GAP, plus 1.
  - Counts down to 1; there is no wrap.
- Bit counter width: clog2(WIDTH+1).
- din changes after acceptance have no effect on the frame in flight.
- b2s_dout is a flop output with no combinational path from inputs. Its only transitions are at state boundaries, so there are no glitches.

Test Plan:
- Reset/idle: hold rst 5 cycles, then release with start=0 for 100 cycles. Expect b2s_dout=1, ready=1, busy=0, done=0 throughout.
- Single frame, WIDTH=8, din=8'hA5, start pulsed once. Expect:
  - Low run of 240 cycles.
  - Then low pulses in the order 16,96,16,96,96,16,96,16, each followed by 32 high cycles.
  - done exactly 240+32+4*16+4*96+8*32+64 cycles after acceptance.
- Loopback with the b2s receiver (WIDTH=64, same clk), sending 64'h0, 64'hFFFF_FFFF_FFFF_FFFF and 64'h0123_4567_89AB_CDEF back to back. Expect receiver finish after each frame with dout equal to the sent word.
- start held high continuously, with din changed mid-frame:
  - One frame per accept.
  - Each frame carries the din sampled at its own acceptance.
  - The next accept occurs one cycle after done.
  - No frame is dropped or duplicated.
- Reset mid-frame: assert rst during bit 3's low pulse. Expect b2s_dout=1 the next cycle, no done, ready=1. A following frame with din=64'h1 decodes correctly at the receiver.
- Boundary: start asserted in the done cycle is ignored. Start asserted in the next cycle is accepted, and b2s_dout falls one cycle later.

Source files
------------

// File: rtl/b2s_transmitter_if.sv
// Request/line bundle between a frame source and the b2s transmitter.
// The master side owns the parallel word and the start request; the slave
// side (the transmitter) owns the handshake status and the serial line.
interface b2s_transmitter_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] din;
  logic             start;
  logic             ready;
  logic             busy;
  logic             done;
  logic             b2s_dout;

  modport master (
    output din,
    output start,
    input  ready,
    input  busy,
    input  done,
    input  b2s_dout
  );

  modport slave (
    input  din,
    input  start,
    output ready,
    output busy,
    output done,
    output b2s_dout
  );
endinterface

// File: rtl/b2s_transmitter.sv
// Pulse-width-coded serialiser. A frame is a start low pulse, a high gap,
// then one low pulse per data bit (short = 1, long = 0, LSB first) each
// followed by a high gap, then an idle-high frame gap before done.
// The line idles high and is driven straight from a flop.
module b2s_transmitter #(
  parameter int WIDTH     = 64,
  parameter int START_LOW = 240,
  parameter int ONE_LOW   = 16,
  parameter int ZERO_LOW  = 96,
  parameter int HIGH_TIME = 32,
  parameter int FRAME_GAP = 64
) (
  input  logic               clk,
  input  logic               rst,
  b2s_transmitter_if.slave   bus
);

  // Longest interval the cycle counter must hold.
  localparam int MAX_A   = (START_LOW > ZERO_LOW) ? START_LOW : ZERO_LOW;
  localparam int MAX_B   = (ONE_LOW > HIGH_TIME) ? ONE_LOW : HIGH_TIME;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_LEN = (MAX_AB > FRAME_GAP) ? MAX_AB : FRAME_GAP;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int BIT_W   = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_START = CNT_W'(START_LOW);
  localparam logic [CNT_W-1:0] LEN_1     = CNT_W'(ONE_LOW);
  localparam logic [CNT_W-1:0] LEN_0     = CNT_W'(ZERO_LOW);
  localparam logic [CNT_W-1:0] LEN_HIGH  = CNT_W'(HIGH_TIME);
  localparam logic [CNT_W-1:0] LEN_GAP   = CNT_W'(FRAME_GAP);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START_L,
    START_H,
    BIT_L,
    BIT_H,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             dout_q, dout_d;
  logic             last_cycle;
  logic             frame_done;

  // The counter holds the remaining cycles of the current interval,
  // so the interval ends while it reads 1.
  assign last_cycle = (cnt_q == CNT_ONE);

  // Next-state, counter and shift-register updates for each interval.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.din;
          bit_d   = '0;
          cnt_d   = LEN_START;
          state_d = START_L;
        end
      end

      START_L: begin
        if (last_cycle) begin
          cnt_d   = LEN_HIGH;
          state_d = START_H;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      START_H: begin
        if (last_cycle) begin
          // Pulse length for the first bit is fixed on entry to BIT_L.
          cnt_d   = shift_q[0] ? LEN_1 : LEN_0;
          state_d = BIT_L;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      BIT_L: begin
        if (last_cycle) begin
          cnt_d   = LEN_HIGH;
          state_d = BIT_H;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      BIT_H: begin
        if (last_cycle) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_d == BIT_LAST) begin
            cnt_d   = LEN_GAP;
            state_d = GAP;
          end else begin
            // The next bit is already in position 0 after the shift.
            cnt_d   = shift_d[0] ? LEN_1 : LEN_0;
            state_d = BIT_L;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      GAP: begin
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // The line is low exactly while the next state is a low-pulse state;
  // registering this keeps the line aligned with the state register.
  always_comb begin
    dout_d = !((state_d == START_L) || (state_d == BIT_L));
  end

  // State, counters, shift register and the registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a plain datapath register, but it is
      // cleared here too so a reset leaves no stale word behind.
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

  // done marks the last frame-gap cycle; the handshake reopens there too,
  // but a start seen in that cycle meets a non-IDLE state and is dropped.
  assign frame_done   = (state_q == GAP) && last_cycle;
  assign bus.done     = frame_done;
  assign bus.ready    = (state_q == IDLE) || frame_done;
  assign bus.busy     = !((state_q == IDLE) || frame_done);
  assign bus.b2s_dout = dout_q;

endmodule

// File: tb/tb_b2s_transmitter.sv
// Bench for b2s_transmitter: an 8-bit and a 64-bit instance share clk/rst.
// Each has a waveform model (expected line level per cycle built from the
// frame rules) checked every cycle, plus a line decoder standing in for
// the receiver, and directed tests with literal expectations.
module tb_b2s_transmitter;

  localparam int T_START = 240;
  localparam int T_ONE   = 16;
  localparam int T_ZERO  = 96;
  localparam int T_HIGH  = 32;
  localparam int T_GAP   = 64;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  b2s_transmitter_if #(.WIDTH(8))  if8 ();
  b2s_transmitter_if #(.WIDTH(64)) if64 ();

  b2s_transmitter #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  b2s_transmitter #(.WIDTH(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {b2s_dout, ready, busy, done} per instance, and the request side.
  logic [3:0]  obs  [2];
  logic        req  [2];
  logic [63:0] data [2];

  assign obs[0]  = {if8.b2s_dout, if8.ready, if8.busy, if8.done};
  assign obs[1]  = {if64.b2s_dout, if64.ready, if64.busy, if64.done};
  assign req[0]  = if8.start;
  assign req[1]  = if64.start;
  assign data[0] = {56'd0, if8.din};
  assign data[1] = if64.din;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int W = (g == 0) ? 8 : 64;

    bit          exp_q [$];   // expected line level for each remaining frame cycle
    bit          live = 1'b0;
    logic [63:0] word;
    logic [3:0]  exp_v;
    int          done_cnt = 0;
    int          low_len = 0;
    int          runs [$];    // completed low-pulse lengths seen on the line
    bit          in_frame = 1'b0;
    int          nbits = 0;
    logic [63:0] rx_sh = '0;
    logic [63:0] rx_q [$];    // words decoded from the line

    // Model: on acceptance, lay out the whole frame as a list of line levels.
    always @(posedge clk) begin
      if (rst) begin
        exp_q.delete();
        live = 1'b1;
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (live && req[g]) begin
        word = data[g];
        repeat (T_START) exp_q.push_back(1'b0);
        repeat (T_HIGH) exp_q.push_back(1'b1);
        for (int i = 0; i < W; i++) begin
          repeat (word[i] ? T_ONE : T_ZERO) exp_q.push_back(1'b0);
          repeat (T_HIGH) exp_q.push_back(1'b1);
        end
        repeat (T_GAP) exp_q.push_back(1'b1);
      end
    end

    // Per-cycle compare, done counting and receiver-style line decoding.
    always @(negedge clk) begin
      if (live) begin
        if (exp_q.size() == 0) exp_v = 4'b1100;
        else if (exp_q.size() == 1) exp_v = {exp_q[0], 3'b101};
        else exp_v = {exp_q[0], 3'b010};
        check((g == 0) ? "line8" : "line64", obs[g], exp_v);
        if (obs[g][0]) done_cnt++;

        if (obs[g][3] == 1'b0) begin
          low_len++;
        end else if (low_len != 0) begin
          runs.push_back(low_len);
          if (low_len >= 231 && low_len <= 249) begin
            in_frame = 1'b1;
            nbits    = 0;
            rx_sh    = '0;
          end else if (in_frame && ((low_len >= 11 && low_len <= 24) ||
                                    (low_len >= 51 && low_len <= 144))) begin
            rx_sh = {(low_len <= 24), rx_sh[63:1]};
            nbits++;
            if (nbits == W) begin
              rx_q.push_back(rx_sh >> (64 - W));
              in_frame = 1'b0;
            end
          end else begin
            in_frame = 1'b0;
          end
          low_len = 0;
        end
      end
    end
  end

  task automatic send(input int g, input logic [63:0] w, output int acc);
    @(negedge clk);
    if (g == 0) begin
      if8.din   = w[7:0];
      if8.start = 1'b1;
    end else begin
      if64.din   = w;
      if64.start = 1'b1;
    end
    @(negedge clk);
    acc = cyc;
    if (g == 0) if8.start = 1'b0;
    else if64.start = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output int d);
    bit seen;
    seen = 1'b0;
    d    = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (obs[g][0]) begin
        seen = 1'b1;
        d    = cyc;
      end
    end
    check("done_within_budget", {63'd0, seen}, 64'd1);
  endtask

  task automatic rx_expect(input int g, input logic [63:0] w, input string name);
    int          n;
    logic [63:0] got;
    if (g == 0) n = g_model[0].rx_q.size();
    else n = g_model[1].rx_q.size();
    check({name, "_present"}, {63'd0, n != 0}, 64'd1);
    if (n != 0) begin
      if (g == 0) got = g_model[0].rx_q.pop_front();
      else got = g_model[1].rx_q.pop_front();
      check(name, got, w);
    end
  endtask

  int acc, d, dc, nr, base;
  int a5_runs [9] = '{240, 16, 96, 16, 96, 96, 16, 96, 16};

  initial begin
    rst = 1'b1;
    if8.start = 1'b0;  if8.din = '0;
    if64.start = 1'b0; if64.din = '0;

    // Reset and idle.
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle8", obs[0], 4'b1100);
    check("idle64", obs[1], 4'b1100);

    // Single 8-bit frame 0xA5: pulse pattern and latency.
    g_model[0].runs.delete();
    send(0, 64'hA5, acc);
    wait_done(0, 3000, d);
    check("a5_latency", d - acc + 1, 1040);
    nr = g_model[0].runs.size();
    check("a5_pulse_count", nr, 9);
    for (int i = 0; i < 9 && i < nr; i++) check("a5_pulse_len", g_model[0].runs[i], a5_runs[i]);
    rx_expect(0, 64'hA5, "a5_word");

    // 64-bit loopback, back to back.
    send(1, 64'h0, acc);
    wait_done(1, 12000, d);
    check("zero_latency", d - acc + 1, 240 + 32 + 64 * 96 + 64 * 32 + 64);
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    wait_done(1, 12000, d);
    check("ones_latency", d - acc + 1, 240 + 32 + 64 * 16 + 64 * 32 + 64);
    send(1, 64'h0123_4567_89AB_CDEF, acc);
    wait_done(1, 12000, d);
    rx_expect(1, 64'h0, "lb_zero");
    rx_expect(1, 64'hFFFF_FFFF_FFFF_FFFF, "lb_ones");
    rx_expect(1, 64'h0123_4567_89AB_CDEF, "lb_mixed");

    // start held high with din changing mid-frame.
    dc = g_model[0].done_cnt;
    @(negedge clk);
    if8.din   = 8'h3C;
    if8.start = 1'b1;
    repeat (50) @(negedge clk);
    if8.din = 8'hC3;
    wait_done(0, 3000, d);
    repeat (50) @(negedge clk);
    if8.din = 8'h81;
    wait_done(0, 3000, d);
    wait_done(0, 3000, d);
    if8.start = 1'b0;
    repeat (20) @(negedge clk);
    check("held_done_count", g_model[0].done_cnt - dc, 3);
    check("held_idle_after", obs[0], 4'b1100);
    rx_expect(0, 64'h3C, "held_f1");
    rx_expect(0, 64'hC3, "held_f2");
    rx_expect(0, 64'h81, "held_f3");
    check("held_no_extra", g_model[0].rx_q.size(), 0);

    // start in the done cycle is dropped; start one cycle later is taken.
    send(0, 64'hFF, acc);
    wait_done(0, 3000, d);
    if8.din   = 8'h5A;
    if8.start = 1'b1;
    @(negedge clk);
    check("done_cycle_start_ignored", obs[0], 4'b1100);
    @(negedge clk);
    if8.start = 1'b0;
    check("next_cycle_start_taken", obs[0], 4'b0010);
    wait_done(0, 3000, d);
    rx_expect(0, 64'hFF, "bnd_ff");
    rx_expect(0, 64'h5A, "bnd_5a");

    // Reset during bit 3's low pulse, then a clean frame.
    base = g_model[1].runs.size();
    dc   = g_model[1].done_cnt;
    send(1, 64'hDEAD_BEEF_0000_0000, acc);
    for (int i = 0; i < 2000 && g_model[1].runs.size() < base + 4; i++) @(negedge clk);
    for (int i = 0; i < 100 && obs[1][3] == 1'b1; i++) @(negedge clk);
    check("bit3_low_reached", {63'd0, obs[1][3]}, 64'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_midframe_line", obs[1], 4'b1100);
    repeat (300) @(negedge clk);
    check("rst_no_done", g_model[1].done_cnt - dc, 0);
    check("rst_no_word", g_model[1].rx_q.size(), 0);
    send(1, 64'h1, acc);
    wait_done(1, 12000, d);
    rx_expect(1, 64'h1, "after_rst_word");

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit in case the flow above stalls.
  initial begin
    #2000000;
    $display("FAIL time_limit: simulation did not reach its end (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
